// File: rtl/mips_pkg.sv
// Shared fetch-path widths and the {pc, instr} entry handed from fetch to decode.
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head word is read straight from the
// storage registers. Callers must not push when full.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CNT_ONE;
    else if (do_pop && !do_push) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  // NOTE: storage is not reset; count guards every read, so stale words are never consumed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues instruction-memory reads for the current PC under a credit
// limit and queues {pc, instr} pairs for decode; redirects drop stale responses.
module instr_fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               pc_advance_o,
  input  logic               flush_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  input  logic               if_ready_i
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]   CREDITS = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] occupancy, outstanding, drop_cnt;
  logic [CNT_W:0]   credits_used;
  logic [ADDR_W-1:0] tag_pc;
  fetch_entry_t     head, rsp_entry;
  logic             rsp_valid, rsp_keep, pop;

  // Queued plus in-flight fetches may never exceed DEPTH, so a response always has room.
  assign credits_used = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req_o   = !rst && !flush_i && (credits_used < CREDITS);
  assign pc_advance_o = imem_req_o && imem_gnt_i;
  assign imem_addr_o  = {pc_i[ADDR_W-1:2], 2'b00};

  assign rsp_valid = imem_rvalid_i && (outstanding != '0);
  assign rsp_keep  = rsp_valid && (drop_cnt == '0) && !flush_i;
  assign rsp_entry = '{pc: tag_pc, instr: imem_rdata_i};

  assign if_valid_o = (occupancy != '0);
  assign pop        = if_valid_o && if_ready_i && !flush_i;
  assign if_instr_o = if_valid_o ? head.instr : '0;
  assign if_pc_o    = if_valid_o ? head.pc    : '0;

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (pc_advance_o),
    .wdata (pc_i),
    .pop   (rsp_valid),
    .rdata (tag_pc),
    .count (outstanding)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (rsp_keep),
    .wdata (rsp_entry),
    .pop   (pop),
    .rdata (head),
    .count (occupancy)
  );

  // Responses still in flight at a redirect belong to the old path and are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (flush_i) begin
      // NOTE: non-blocking so every reader this cycle sees the pre-edge drop_cnt.
      drop_cnt <= rsp_valid ? (outstanding - CNT_ONE) : outstanding;
    end else if (rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CNT_ONE;
    end
  end

  a_rvalid_has_tag: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (outstanding != '0));

endmodule
